// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: address width, reset vector, opcodes and the
// fetch-state encoding used by the instruction-fetch stage.
package mips_pkg;

    localparam int          PC_WIDTH  = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FULL
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel: one request/response pair between the fetch
// stage (master) and the instruction memory (slave).
interface if_stage_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic                imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );
endinterface

// File: rtl/if_skid_buffer.sv
// One-entry {instr, pc} holding register that parks a fetched word while the
// IF/ID register is stalled.
module if_skid_buffer #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                unload,
    input  logic                clear,
    input  logic [31:0]         load_instr,
    input  logic [PC_WIDTH-1:0] load_pc,
    output logic                valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc
);
    logic                valid_reg;
    logic [31:0]         instr_reg;
    logic [PC_WIDTH-1:0] pc_reg;

    // clear/unload win over load so a redirect can never leave a stale entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc_reg    <= '0;
        end else if (clear || unload) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= load_instr;
            pc_reg    <= load_pc;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC/request FSM, redirect handling and the IF/ID register,
// with a one-entry skid buffer absorbing a response that lands during a stall.
module if_stage #(
    parameter int                  PC_WIDTH = mips_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(mips_pkg::RESET_PC)
) (
    input  logic                clk,
    input  logic                rst_n,
    if_stage_if.master          imem,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [PC_WIDTH-1:0] if_pc_plus4,
    output logic [5:0]          if_opcode
);
    import mips_pkg::*;

    fetch_state_t        state_reg, state_next;
    logic [PC_WIDTH-1:0] req_addr_reg, req_addr_next;
    logic [PC_WIDTH-1:0] target_reg, target_next;
    logic                kill_reg, kill_next;
    logic                valid_reg, valid_next;
    logic [31:0]         instr_reg, instr_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;

    logic                redirect;
    logic                take_rsp;
    logic                skid_load, skid_unload, skid_clear;
    logic                skid_valid;
    logic [31:0]         skid_instr;
    logic [PC_WIDTH-1:0] skid_pc;

    assign redirect = flush | branch_taken;
    assign take_rsp = (state_reg == WAIT) && imem.imem_rvalid && !kill_reg && !redirect;

    if_skid_buffer #(.PC_WIDTH(PC_WIDTH)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_instr (imem.imem_rdata),
        .load_pc    (req_addr_reg),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            req_addr_reg <= RESET_PC;
            target_reg   <= RESET_PC;
            kill_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP_INSTR;
            pc_reg       <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            req_addr_reg <= req_addr_next;
            target_reg   <= target_next;
            kill_reg     <= kill_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            pc_reg       <= pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_addr_next = req_addr_reg;
        target_next   = target_reg;
        kill_next     = kill_reg;
        valid_next    = valid_reg;
        instr_next    = instr_reg;
        pc_next       = pc_reg;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = WAIT;
                if (redirect) begin
                    req_addr_next = branch_target;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // a response arriving now is dropped; otherwise the in-flight one must be
                    if (imem.imem_rvalid) begin
                        req_addr_next = branch_target;
                        kill_next     = 1'b0;
                    end else begin
                        target_next = branch_target;
                        kill_next   = 1'b1;
                    end
                end else if (imem.imem_rvalid) begin
                    if (kill_reg) begin
                        req_addr_next = target_reg;
                        kill_next     = 1'b0;
                    end else begin
                        req_addr_next = req_addr_reg + PC_WIDTH'(4);
                        if (valid_reg && stall) begin
                            skid_load  = 1'b1;
                            state_next = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    req_addr_next = branch_target;
                    state_next    = WAIT;
                end else if (!stall) begin
                    skid_unload = 1'b1;
                    state_next  = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase

        // IF/ID register: redirect kills, then a fresh response, then the parked word, then drain
        if (redirect) begin
            valid_next = 1'b0;
            instr_next = NOP_INSTR;
            skid_clear = 1'b1;
        end else if (take_rsp && (!valid_reg || !stall)) begin
            valid_next = 1'b1;
            instr_next = imem.imem_rdata;
            pc_next    = req_addr_reg;
        end else if ((state_reg == FULL) && !stall) begin
            valid_next = skid_valid;
            instr_next = skid_valid ? skid_instr : NOP_INSTR;
            pc_next    = skid_pc;
        end else if (valid_reg && !stall) begin
            valid_next = 1'b0;
            instr_next = NOP_INSTR;
        end
    end

    assign imem.imem_req  = (state_reg == WAIT);
    assign imem.imem_addr = req_addr_reg;

    assign if_valid    = valid_reg;
    assign if_instr    = instr_reg;
    assign if_pc       = pc_reg;
    assign if_pc_plus4 = pc_reg + PC_WIDTH'(4);
    assign if_opcode   = opcode_of(instr_reg);
endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a variable-latency memory, random stall/redirect,
// and an in-order program-counter scoreboard of delivered instructions.
`timescale 1ns/1ps
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [5:0]  if_opcode;

    if_stage_if #(.PC_WIDTH(32)) bus ();

    if_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_opcode     (if_opcode)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ncons = 0;
    int          lat = 0;
    int          fixed_lat = 0;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          last_v = -1;
    int          n0;
    bit          busy = 0;
    bit          new_req = 0;
    bit          chk_gap = 0;
    bit          chk_next_addr = 0;
    bit          force_stall = 0;
    bit          force_flush = 0;
    bit          force_br = 0;
    bit          found;
    logic [31:0] force_target = 32'h0;
    logic [31:0] want_addr = 32'h0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] exp_pc = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // program image: opcode rotates through the MIPS classes, low bits tagged by address
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [5:0] opc;
        case ((a >> 2) % 5)
            0:       opc = OPC_LW;
            1:       opc = OPC_SW;
            2:       opc = OPC_BEQ;
            3:       opc = OPC_ADDI;
            default: opc = OPC_RTYPE;
        endcase
        return {opc, 26'((a >> 2) * 977 + 1)};
    endfunction

    task automatic step();
        logic [31:0] w;
        @(negedge clk);
        cyc++;
        new_req = 0;
        w = memword(exp_pc);

        // the held instruction must always be the next one in program order
        if (rst_n) begin
            if (!if_valid) begin
                check("nop_when_invalid", if_instr, NOP_INSTR);
            end else begin
                check("if_pc", if_pc, exp_pc);
                check("if_instr", if_instr, w);
                check("if_opcode", 32'(if_opcode), 32'(w[31:26]));
                check("if_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
                if (chk_gap) begin
                    if (last_v >= 0) check("valid_gap", 32'(cyc - last_v), 32'd4);
                    last_v = cyc;
                end
            end
        end

        // memory: latency 0 answers in the request cycle; stray rvalid when idle
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (!rst_n) begin
            busy = 0;
        end else if (bus.imem_req) begin
            if (!busy) begin
                busy     = 1;
                new_req  = 1;
                cap_addr = bus.imem_addr;
                lat      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                if (chk_next_addr) begin
                    check("redirect_addr", bus.imem_addr, want_addr);
                    chk_next_addr = 0;
                end
            end else begin
                check("addr_hold", bus.imem_addr, cap_addr);
            end
            if (lat == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memword(cap_addr);
                busy = 0;
            end else begin
                lat--;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            bus.imem_rvalid = 1'b1;
        end

        stall        = force_stall || ($urandom_range(0, 99) < stall_pct);
        flush        = 1'b0;
        branch_taken = 1'b0;
        if (force_flush || force_br) begin
            flush         = force_flush;
            branch_taken  = force_br;
            branch_target = force_target;
        end else if ($urandom_range(0, 99) < redir_pct) begin
            if ($urandom_range(0, 1) == 1) flush = 1'b1;
            else branch_taken = 1'b1;
            branch_target = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        end

        if (rst_n) begin
            if (flush || branch_taken) begin
                exp_pc = branch_target;
            end else if (if_valid && !stall) begin
                $display("instr pc=%h word=%h opc=%b", if_pc, if_instr, if_opcode);
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        repeat (2) step();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, NOP_INSTR);
        check("rst_pc", if_pc, RESET_PC);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);

        // single-cycle memory, free-running stream
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        step();
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, RESET_PC);
        step();
        check("lw_opcode", 32'(if_opcode), 32'(OPC_LW));
        for (int k = 2; k < 12; k++) begin
            step();
            check("b2b_valid", {31'd0, if_valid}, 32'd1);
            check("stream_addr", bus.imem_addr, 32'(4 * k));
            check("stream_pc", if_pc, 32'(4 * (k - 1)));
        end

        // four-cycle stall: skid absorbs one word, request line idles
        force_stall = 1;
        step();
        repeat (3) begin
            step();
            check("full_noreq", {31'd0, bus.imem_req}, 32'd0);
            check("full_valid", {31'd0, if_valid}, 32'd1);
        end
        force_stall = 0;
        repeat (6) step();

        // three-cycle memory: one if_valid pulse every four cycles
        fixed_lat = 3;
        repeat (8) step();
        n0 = ncons;
        last_v = -1;
        chk_gap = 1;
        repeat (30) step();
        chk_gap = 0;
        check("lat3_count_ok", {31'd0, (ncons - n0) >= 7}, 32'd1);

        // branch while a two-cycle fetch is in flight
        fixed_lat = 2;
        repeat (6) step();
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            step();
            found = new_req;
        end
        check("br_found_req", {31'd0, found}, 32'd1);
        force_br = 1;
        force_target = 32'h40;
        step();
        force_br = 0;
        chk_next_addr = 1;
        want_addr = 32'h40;
        step();
        check("br_valid0_a", {31'd0, if_valid}, 32'd0);
        step();
        check("br_valid0_b", {31'd0, if_valid}, 32'd0);
        repeat (8) step();
        check("br_addr_seen", {31'd0, chk_next_addr}, 32'd0);

        // flush with the skid full, then flush coinciding with rvalid under stall
        fixed_lat = 0;
        for (int c = 0; c < 2; c++) begin
            repeat (4) step();
            force_stall = 1;
            if (c == 0) repeat (2) step();
            force_flush = 1;
            force_target = (c == 0) ? 32'h80 : 32'hC0;
            step();
            force_flush = 0;
            force_stall = 0;
            step();
            check("fl_valid0", {31'd0, if_valid}, 32'd0);
            check("fl_req", {31'd0, bus.imem_req}, 32'd1);
            check("fl_addr", bus.imem_addr, force_target);
            repeat (3) step();
        end

        // asynchronous reset in the middle of a slow fetch
        fixed_lat = 3;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        check("mid_rst_instr", if_instr, NOP_INSTR);
        check("mid_rst_pc", if_pc, RESET_PC);
        check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        exp_pc = RESET_PC;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        chk_next_addr = 1;
        want_addr = RESET_PC;
        fixed_lat = -1;
        repeat (3) step();
        check("post_rst_req_seen", {31'd0, chk_next_addr}, 32'd0);

        // random stall / redirect / latency soak
        stall_pct = 30;
        redir_pct = 6;
        n0 = ncons;
        repeat (2000) step();
        check("progress", {31'd0, (ncons - n0) > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
